// File: rtl/bram_loader_pkg.sv
// Shared constants and FSM state type for the BRAM tensor loader and the conv read side.
package bram_loader_pkg;

    localparam int DW_DEF        = 16;
    localparam int AW_DEF        = 6;
    localparam int N_WORDS_DEF   = 27;
    localparam int W_BASE_DEF    = 27;
    localparam int PARK_ADDR_DEF = 63;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_IN,
        LOAD_W,
        DONE
    } state_t;

endpackage

// File: rtl/bram_loader_if.sv
// Valid/ready word stream feeding the BRAM loader.
interface bram_loader_if
    import bram_loader_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/bram_loader.sv
// Streams one frame (input tensor, then weight tensor) into a dual-port BRAM,
// one registered write per accepted beat, and reports the frame checksum.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int N_WORDS   = N_WORDS_DEF,
    parameter int W_BASE    = W_BASE_DEF,
    parameter int PARK_ADDR = PARK_ADDR_DEF
) (
    input  logic          clk,
    input  logic          RESET_N,
    input  logic          start,
    input  logic          abort,
    bram_loader_if.slave  strm,
    output logic          wren_a,
    output logic [AW-1:0] address_a,
    output logic [DW-1:0] data_a,
    output logic          wren_b,
    output logic [AW-1:0] address_b,
    output logic [DW-1:0] data_b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] sum;
    logic          beat;
    logic          last;

    assign strm.s_ready = (state == LOAD_IN) || (state == LOAD_W);
    assign busy         = (state != IDLE);
    // An abort cycle still shows s_ready, but its beat must not be consumed.
    assign beat         = strm.s_valid && strm.s_ready && !abort;
    assign last         = (idx == AW'(N_WORDS - 1));

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            idx       <= '0;
            sum       <= '0;
            checksum  <= '0;
            done      <= 1'b0;
            wren_a    <= 1'b0;
            address_a <= AW'(PARK_ADDR);
            data_a    <= '0;
            wren_b    <= 1'b0;
            address_b <= AW'(PARK_ADDR);
            data_b    <= '0;
        end else begin
            wren_a    <= 1'b0;
            address_a <= AW'(PARK_ADDR);
            data_a    <= '0;
            wren_b    <= 1'b0;
            address_b <= AW'(PARK_ADDR);
            data_b    <= '0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= LOAD_IN;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                LOAD_IN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (beat) begin
                        wren_a    <= 1'b1;
                        address_a <= idx;
                        data_a    <= strm.s_data;
                        sum       <= sum + strm.s_data;
                        if (last) begin
                            idx   <= '0;
                            state <= LOAD_W;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (beat) begin
                        wren_b    <= 1'b1;
                        address_b <= AW'(W_BASE) + idx;
                        data_b    <= strm.s_data;
                        sum       <= sum + strm.s_data;
                        if (last) begin
                            idx      <= '0;
                            state    <= DONE;
                            done     <= 1'b1;
                            checksum <= sum + strm.s_data;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Bench for bram_loader: frame-level reference model checked every cycle, plus literal frame results.
module tb_bram_loader;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int NW = 27;
    localparam int WB = 27;
    localparam int PK = 63;

    logic          clk     = 1'b0;
    logic          RESET_N = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic          wren_a, wren_b, busy, done;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_a, data_b, checksum;

    bram_loader_if #(.DW(DW)) strm ();

    bram_loader #(
        .DW(DW), .AW(AW), .N_WORDS(NW), .W_BASE(WB), .PARK_ADDR(PK)
    ) dut (
        .clk       (clk),
        .RESET_N   (RESET_N),
        .start     (start),
        .abort     (abort),
        .strm      (strm),
        .wren_a    (wren_a),
        .address_a (address_a),
        .data_a    (data_a),
        .wren_b    (wren_b),
        .address_b (address_b),
        .data_b    (data_b),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: a frame is 2*NW accepted words counted globally;
    // words below NW go to port A, the rest to port B.
    bit          m_active = 0;
    bit          m_done   = 0;
    int          m_count  = 0;
    logic [DW-1:0] m_sum  = '0;
    logic [DW-1:0] m_chk  = '0;
    bit          m_wa = 0, m_wb = 0;
    int          m_aa = PK, m_ab = PK;
    logic [DW-1:0] m_da = '0, m_db = '0;

    int done_cnt = 0, wa_cnt = 0, wb_cnt = 0;
    logic [DW-1:0] mem [64];

    always begin
        @(negedge clk);
        if (!RESET_N) begin
            m_active = 0; m_done = 0; m_count = 0; m_sum = '0; m_chk = '0;
            m_wa = 0; m_wb = 0; m_aa = PK; m_ab = PK; m_da = '0; m_db = '0;
        end
        chk("s_ready",   {31'd0, strm.s_ready}, {31'd0, m_active});
        chk("busy",      {31'd0, busy},         {31'd0, (m_active || m_done)});
        chk("done",      {31'd0, done},         {31'd0, m_done});
        chk("checksum",  {16'd0, checksum},     {16'd0, m_chk});
        chk("wren_a",    {31'd0, wren_a},       {31'd0, m_wa});
        chk("address_a", {26'd0, address_a},    32'(m_aa));
        chk("wren_b",    {31'd0, wren_b},       {31'd0, m_wb});
        chk("address_b", {26'd0, address_b},    32'(m_ab));
        if (m_wa) chk("data_a", {16'd0, data_a}, {16'd0, m_da});
        if (m_wb) chk("data_b", {16'd0, data_b}, {16'd0, m_db});

        if (wren_a === 1'b1) begin mem[address_a] = data_a; wa_cnt++; end
        if (wren_b === 1'b1) begin mem[address_b] = data_b; wb_cnt++; end
        if (done === 1'b1) done_cnt++;

        // Predict the state after the coming posedge from the inputs now stable.
        if (RESET_N) begin
            m_wa = 0; m_wb = 0; m_aa = PK; m_ab = PK; m_da = '0; m_db = '0;
            if (m_active) begin
                m_done = 0;
                if (abort) begin
                    m_active = 0;
                end else if (strm.s_valid) begin
                    if (m_count < NW) begin
                        m_wa = 1; m_aa = m_count; m_da = strm.s_data;
                    end else begin
                        m_wb = 1; m_ab = WB + (m_count - NW); m_db = strm.s_data;
                    end
                    m_sum = m_sum + strm.s_data;
                    m_count++;
                    if (m_count == 2 * NW) begin
                        m_active = 0; m_done = 1; m_chk = m_sum;
                    end
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (start && !abort) begin
                m_active = 1; m_count = 0; m_sum = '0;
            end
        end
    end

    logic [DW-1:0] vals [54];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit toggle, input int start_at, input int stop_after);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < stop_after; i++) begin
            strm.s_valid = 1'b1;
            strm.s_data  = vals[i];
            start        = (i == start_at);
            tick();
            start = 1'b0;
            if (toggle) begin
                strm.s_valid = 1'b0;
                strm.s_data  = 16'hDEAD;
                tick();
            end
        end
        strm.s_valid = 1'b0;
        strm.s_data  = '0;
    endtask

    int d0, a0, b0;

    task automatic snap();
        d0 = done_cnt; a0 = wa_cnt; b0 = wb_cnt;
    endtask

    initial begin
        strm.s_valid = 1'b0;
        strm.s_data  = '0;
        repeat (3) tick();
        RESET_N = 1'b1;
        tick();

        // Sequential values 1..54, back to back.
        for (int i = 0; i < 54; i++) vals[i] = 16'(i + 1);
        snap();
        run_frame(0, -1, 54);
        repeat (3) tick();
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t1_checksum",   {16'd0, checksum},  32'd1485);
        chk("t1_writes_a",   32'(wa_cnt - a0),   32'd27);
        chk("t1_writes_b",   32'(wb_cnt - b0),   32'd27);
        for (int i = 0; i < 54; i++) chk("t1_mem", {16'd0, mem[i]}, 32'(i + 1));

        // Valid toggling, all ones.
        for (int i = 0; i < 54; i++) vals[i] = 16'h0001;
        snap();
        run_frame(1, -1, 54);
        repeat (3) tick();
        chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t2_checksum",   {16'd0, checksum},  32'd54);
        chk("t2_writes_a",   32'(wa_cnt - a0),   32'd27);
        chk("t2_writes_b",   32'(wb_cnt - b0),   32'd27);

        // Abort after 10 input beats; the aborted beat carries a value that must not land.
        for (int i = 0; i < 54; i++) vals[i] = 16'(100 + i);
        snap();
        run_frame(0, -1, 10);
        abort = 1'b1; strm.s_valid = 1'b1; strm.s_data = 16'h0BAD;
        tick();
        abort = 1'b0; strm.s_valid = 1'b0;
        repeat (3) tick();
        chk("t3_writes_a",   32'(wa_cnt - a0),   32'd10);
        chk("t3_done_count", 32'(done_cnt - d0), 32'd0);
        chk("t3_checksum",   {16'd0, checksum},  32'd54);
        chk("t3_busy",       {31'd0, busy},      32'd0);
        chk("t3_mem10",      {16'd0, mem[10]},   32'd1);

        // Abort and start together in idle: stays idle.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("t3_abort_wins", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 54; i++) vals[i] = 16'(i + 1);
        snap();
        run_frame(0, -1, 54);
        repeat (3) tick();
        chk("t3b_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t3b_checksum",   {16'd0, checksum},  32'd1485);

        // Start pulsed during LOAD_W, values 3*(i+1).
        for (int i = 0; i < 54; i++) vals[i] = 16'(3 * (i + 1));
        snap();
        run_frame(0, 35, 54);
        repeat (4) tick();
        chk("t4_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t4_checksum",   {16'd0, checksum},  32'd4455);
        chk("t4_busy",       {31'd0, busy},      32'd0);

        // All ones-words wrap.
        for (int i = 0; i < 54; i++) vals[i] = 16'hFFFF;
        run_frame(0, -1, 54);
        repeat (3) tick();
        chk("t5_checksum", {16'd0, checksum}, 32'h0000FFCA);

        // Reset at beat 40.
        for (int i = 0; i < 54; i++) vals[i] = 16'(i + 7);
        snap();
        run_frame(0, -1, 40);
        RESET_N = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
        repeat (5) tick();
        chk("t6_done_count", 32'(done_cnt - d0), 32'd0);
        chk("t6_checksum",   {16'd0, checksum},  32'd0);
        chk("t6_busy",       {31'd0, busy},      32'd0);
        chk("t6_address_a",  {26'd0, address_a}, 32'd63);
        chk("t6_address_b",  {26'd0, address_b}, 32'd63);

        for (int i = 0; i < 54; i++) vals[i] = 16'(i + 1);
        snap();
        run_frame(0, -1, 54);
        repeat (3) tick();
        chk("t6b_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t6b_checksum",   {16'd0, checksum},  32'd1485);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
